// File: rtl/bus_arbiter.sv
// Round-robin central arbiter for one shared bus, with registered one-hot grant.
// Optional grant timeout/revoke enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int unsigned NUM_CORES      = 4,
    parameter int unsigned OWNER_W        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] Bus_RQ,
    input  logic                 Bus_Mem_Ready,
    output logic [NUM_CORES-1:0] Bus_GRANT,
    output logic                 Bus_Busy,
    output logic [OWNER_W-1:0]   Grant_Owner,
    output logic                 Timeout_Flag
);

    if (NUM_CORES < 2 || NUM_CORES > 16 || OWNER_W != $clog2(NUM_CORES) || TIMEOUT_CYCLES < 2)
    begin : g_cfg_err
        $error("bus_arbiter: invalid parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANTED = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic                 busy_q, busy_d;

    logic [NUM_CORES-1:0] eligible_c;
    logic                 found_c;
    logic [OWNER_W-1:0]   winner_c;
    logic [OWNER_W-1:0]   cand_c;
    logic [OWNER_W-1:0]   next_ptr_c;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CORES-1:0] mask_q, mask_d;
    logic                 tflag_q, tflag_d;

    assign eligible_c   = Bus_RQ & ~mask_q;
    assign Timeout_Flag = tflag_q;
`else
    assign eligible_c   = Bus_RQ;
    assign Timeout_Flag = 1'b0;
`endif

    // First eligible requester searching upward from rr_ptr, wrapping.
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        cand_c   = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            cand_c = OWNER_W'((32'(rr_ptr_q) + 32'(i)) % NUM_CORES);
            if (!found_c && eligible_c[cand_c]) begin
                found_c  = 1'b1;
                winner_c = cand_c;
            end
        end
    end

    assign next_ptr_c = (32'(owner_q) == NUM_CORES - 1) ? '0 : owner_q + OWNER_W'(1);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tflag_d  = 1'b0;
        mask_d   = mask_q & Bus_RQ;
`endif
        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (!Bus_Mem_Ready && found_c) begin
                    grant_d = NUM_CORES'(1) << winner_c;
                    owner_d = winner_c;
                    state_d = ST_GRANTED;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANTED: begin
`ifdef BUS_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (!Bus_RQ[owner_q]) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr_c;
                    state_d  = Bus_Mem_Ready ? ST_RELEASE : ST_IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    grant_d         = '0;
                    tflag_d         = 1'b1;
                    rr_ptr_d        = next_ptr_c;
                    mask_d[owner_q] = 1'b1;
                    state_d         = ST_RELEASE;
                    cnt_d           = '0;
                end
`endif
            end
            ST_RELEASE: begin
                grant_d = '0;
`ifdef BUS_ARB_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (!Bus_Mem_Ready) begin
                    state_d = ST_IDLE;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LIMIT) begin
                    tflag_d = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            mask_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            tflag_q <= tflag_d;
        end
    end
`endif

    assign Bus_GRANT   = grant_q;
    assign Bus_Busy    = busy_q;
    assign Grant_Owner = owner_q;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for one shared bus, either the instruction bus or the data bus; one instance is placed per bus.
- Answers the level request (RQ) from each core's arbitration submodule with a one-hot, registered GRANT.
- Ownership is held until the owner drops RQ. A handover is allowed only after the memory's Ready line has returned low.
- Selection among requesters is round-robin, so no core can be starved.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..16).
- OWNER_W, 2, width of the owner index; must equal ceil(log2(NUM_CORES)).
- TIMEOUT_CYCLES, 256, maximum number of cycles a grant may be held (used only with the optional feature).

Ports:
- clk  input  1  system clock; everything is sampled on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Bus_RQ  input  NUM_CORES  bus request, one bit per core, held as a level.
- Bus_Mem_Ready  input  1  Ready line from the memory on this bus.
- Bus_GRANT  output  NUM_CORES  one-hot grant, registered.
- Bus_Busy  output  1  high whenever the FSM is not in IDLE.
- Grant_Owner  output  OWNER_W  index of the current or most recent owner.
- Timeout_Flag  output  1  one-cycle pulse when a grant is revoked (optional feature only; tied to 0 otherwise).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, Bus_GRANT=0, Bus_Busy=0, Grant_Owner=0.
  - Round-robin pointer rr_ptr=0; Timeout_Flag=0; timeout counter=0; revoke mask=0.
- All outputs are registered; no combinational path from any input to any output.
- State IDLE:
  - If (Bus_RQ & ~mask) != 0, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_CORES.
  - On that edge: Bus_GRANT is set one-hot for the winner, Grant_Owner=winner, state→GRANTED.
  - Latency: RQ sampled high at edge k gives GRANT high after edge k.
  - Arbitration requires Bus_Mem_Ready=0; if Ready is high, stay in IDLE.
- State GRANTED:
  - Bus_GRANT is held while Bus_RQ[owner]=1. Requests from other cores are ignored and stay pending, since RQ is a level.
  - When Bus_RQ[owner]=0 is sampled: Bus_GRANT→0 on that edge, rr_ptr=(owner+1) mod NUM_CORES.
  - Next state is RELEASE if Bus_Mem_Ready=1, otherwise IDLE.
- State RELEASE:
  - Bus_GRANT=0; wait until Bus_Mem_Ready=0, then go to IDLE.
  - Ready stuck high keeps the arbiter here indefinitely unless the optional feature is compiled in.
- Handover spacing: at least one full cycle with Bus_GRANT=0 between any two grants. Two grant bits are never high at once.
- Boundaries:
  - Simultaneous RQs: round-robin order from rr_ptr; after core NUM_CORES-1 wins, rr_ptr wraps to 0.
  - Owner RQ dropping and another core's RQ rising on the same edge: the new request is served only after the drop is processed (no same-edge handover).
  - Reset asserted mid-grant: Bus_GRANT clears immediately (asynchronously).
- Bus_Busy = (state != IDLE), registered together with the state.
- FSM encoding: 2 bits, IDLE=00, GRANTED=01, RELEASE=10; the unused code returns to IDLE with GRANT=0.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in GRANTED, cleared on entry.
  - When it reaches TIMEOUT_CYCLES-1 with the owner's RQ still high: Bus_GRANT→0, Timeout_Flag pulses for 1 cycle, rr_ptr=owner+1, mask[owner]=1, state→RELEASE.
  - The same revoke path applies in RELEASE if Ready stays high for TIMEOUT_CYCLES; in that case the FSM is forced to IDLE.
  - mask[i] clears once Bus_RQ[i]=0 is sampled. A timed-out core must drop RQ for at least one cycle before it is eligible again.
- Without the macro: no counter and no mask; Timeout_Flag is constant 0; grants are held indefinitely.

Test Plan:
- Reset held low while Bus_RQ=4'b1111 → Bus_GRANT=0, Bus_Busy=0, Grant_Owner=0. After release, first grant is 4'b0001 one edge later.
- Single request: Bus_RQ=4'b0100, Ready=0 → GRANT=4'b0100 after 1 edge. RQ low → GRANT=0 on the next edge, rr_ptr=3.
- Round-robin: Bus_RQ=4'b1111 held, each owner drops RQ for 1 cycle after 3 cycles of ownership → grant order 0,1,2,3,0. At least one GRANT=0 cycle between grants; never two bits set.
- Ready hold-off: owner drops RQ while Ready=1, Ready stays high 5 cycles, another RQ pending → FSM in RELEASE. No new grant until 1 edge after Ready falls.
- Reset pulse mid-grant (GRANT=4'b0010) → GRANT=0 immediately, asynchronously, before the next clk edge. FSM restarts in IDLE with rr_ptr=0.
- BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - Core 1 holds RQ → GRANT revoked after 8 cycles, Timeout_Flag=1 for exactly 1 cycle, pending core 2 granted next.
  - Core 1 is not re-granted until its RQ toggles low.
